// File: rtl/mem_arbiter_pkg.sv
// Shared CPU memory definitions: arbiter state encoding, access sizes and
// the store-side lane helpers used by mem_arbiter.
package cpuDefine;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } ArbState;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    // Size 3 falls into the default arm everywhere, so it behaves as a word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            MEM_B:   return 1'b0;
            MEM_H:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            MEM_B:   return 4'b0001 << a;
            MEM_H:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] place_wdata(input logic [1:0] size, input logic [31:0] w);
        case (size)
            MEM_B:   return {4{w[7:0]}};
            MEM_H:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and SRAM bus around mem_arbiter.
// slave = the arbiter itself; master = the CPU/SRAM environment around it.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsign;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_err;

    logic        sram_req;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ack;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_unsign, d_addr, d_wdata,
               sram_rdata, sram_ack,
        output if_rdata, if_ready, d_rdata, d_ready, d_err,
               sram_req, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_unsign, d_addr, d_wdata,
               sram_rdata, sram_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, d_err,
               sram_req, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/mem_arbiter_load_align.sv
// Combinational load path: picks the addressed byte/half out of the
// registered SRAM word and sign- or zero-extends it.
module load_align
    import cpuDefine::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        unsign,
    output logic [31:0] rdata
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[8*addr_lo +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            MEM_B:   rdata = {{24{b[7] & ~unsign}}, b};
            MEM_H:   rdata = {{16{h[15] & ~unsign}}, h};
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding SRAM arbiter between instruction fetch and data access.
// Define MEM_ARB_FAIR_EN to bound how long fetch can be starved by data.
module mem_arbiter
    import cpuDefine::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    ArbState     state_q, state_d;
    logic        data_gnt_q, data_gnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] load_data;
    logic [1:0]  d_addr_lo;
    logic        mis, fetch_pri, data_win, store;

    assign d_addr_lo = bus.d_addr[1:0];
    assign mis       = misaligned(bus.d_size, d_addr_lo);
    assign data_win  = bus.d_req && !fetch_pri;

`ifdef MEM_ARB_FAIR_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_d;

    assign fetch_pri = bus.if_req && (starve_q == STARVE_LIM);

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (data_win) begin
                if (bus.if_req && starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
            end else if (bus.if_req) begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign fetch_pri = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        data_gnt_d = data_gnt_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (data_win) begin
                    data_gnt_d = 1'b1;
                    err_d      = mis;
                    rdata_d    = '0;
                    // Misaligned accesses answer straight away without touching the bus.
                    state_d    = mis ? RESP : DATA;
                end else if (bus.if_req) begin
                    data_gnt_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH, DATA: begin
                if (bus.sram_ack) begin
                    rdata_d = bus.sram_rdata;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            data_gnt_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            data_gnt_q <= data_gnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    load_align u_load_align (
        .word   (rdata_q),
        .addr_lo(d_addr_lo),
        .size   (bus.d_size),
        .unsign (bus.d_unsign),
        .rdata  (load_data)
    );

    // Request inputs are held until ready, so the bus fields follow them directly.
    assign store          = (state_q == DATA) && bus.d_we;
    assign bus.sram_req   = (state_q == FETCH) || (state_q == DATA);
    assign bus.sram_addr  = (state_q == FETCH) ? {bus.if_addr[31:2], 2'b00} :
                            (state_q == DATA)  ? {bus.d_addr[31:2], 2'b00}  : '0;
    assign bus.sram_we    = store ? byte_en(bus.d_size, d_addr_lo) : 4'b0000;
    assign bus.sram_wdata = store ? place_wdata(bus.d_size, bus.d_wdata) : '0;

    assign bus.if_ready = (state_q == RESP) && !data_gnt_q;
    assign bus.d_ready  = (state_q == RESP) && data_gnt_q;
    assign bus.d_err    = bus.d_ready && err_q;
    assign bus.if_rdata = bus.if_ready ? rdata_q : '0;
    assign bus.d_rdata  = (bus.d_ready && !err_q && !bus.d_we) ? load_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requests push expected bus/response
// entries, an SRAM responder and the request driver pop and compare them.
module tb_mem_arbiter;

    typedef struct {
        logic        is_data;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } bus_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int req_cycles = 0;
    int wait_cnt = 0;
    int ack_dly = 0;
    logic [31:0] rd_word = '0;
    bit bus_chk = 1'b1;
    bit force_ack = 1'b0;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    bit    grant_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: acks after ack_dly wait cycles and checks the bus fields.
    always @(negedge clk) begin
        bus_t b;
        bus.sram_ack   = 1'b0;
        bus.sram_rdata = '0;
        if (bus.sram_req) begin
            req_cycles++;
            if (wait_cnt >= ack_dly) begin
                bus.sram_ack   = 1'b1;
                bus.sram_rdata = rd_word;
                wait_cnt       = 0;
                if (bus_chk) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected", 32'd1, 32'd0);
                    end else begin
                        b = bus_q.pop_front();
                        chk("sram_addr", bus.sram_addr, b.addr);
                        chk("sram_we", {28'd0, bus.sram_we}, {28'd0, b.we});
                        chk("sram_wdata", bus.sram_wdata, b.wdata);
                    end
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (force_ack) begin
                bus.sram_ack   = 1'b1;
                bus.sram_rdata = 32'hDEAD_DEAD;
            end
        end
    end

    task automatic drop_reqs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_size   = 2'd0;
        bus.d_unsign = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
    endtask

    task automatic do_req(input bit fetch, input logic [31:0] addr, input logic we,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input logic [31:0] rword, input int dly);
        resp_t r;
        bus_t b;
        logic [1:0] lo, sz;
        logic [31:0] sel;
        bit mis, seen;
        int t0, start_req;
        lo  = addr[1:0];
        sz  = (size == 2'd3) ? 2'd2 : size;
        mis = !fetch && ((sz == 2'd1 && lo[0]) || (sz == 2'd2 && lo != 2'd0));
        r.is_data = !fetch;
        r.err     = mis;
        r.lat     = mis ? 2 : 3 + dly;
        if (fetch) r.rdata = rword;
        else if (mis || we) r.rdata = '0;
        else if (sz == 2'd0) begin
            sel = (rword >> (8 * lo)) & 32'hFF;
            r.rdata = (!uns && sel[7]) ? (sel | 32'hFFFF_FF00) : sel;
        end else if (sz == 2'd1) begin
            sel = (rword >> (8 * lo)) & 32'hFFFF;
            r.rdata = (!uns && sel[15]) ? (sel | 32'hFFFF_0000) : sel;
        end else r.rdata = rword;
        b.addr = addr & ~32'd3;
        if (fetch || !we) begin
            b.we = 4'b0000;
            b.wdata = '0;
        end else if (sz == 2'd0) begin
            b.we = 4'b0001 << lo;
            b.wdata = (wdata & 32'hFF) * 32'h0101_0101;
        end else if (sz == 2'd1) begin
            b.we = lo[1] ? 4'b1100 : 4'b0011;
            b.wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
        end else begin
            b.we = 4'b1111;
            b.wdata = wdata;
        end
        resp_q.push_back(r);
        if (!mis) bus_q.push_back(b);
        rd_word = rword;
        ack_dly = dly;
        @(posedge clk); #1;
        if (fetch) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.d_req    = 1'b1;
            bus.d_we     = we;
            bus.d_size   = size;
            bus.d_unsign = uns;
            bus.d_addr   = addr;
            bus.d_wdata  = wdata;
        end
        t0 = cyc;
        start_req = req_cycles;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.if_ready || bus.d_ready) seen = 1'b1;
        end
        r = resp_q.pop_front();
        if (!seen) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            chk("grant_side", {31'd0, bus.d_ready}, {31'd0, r.is_data});
            chk("one_ready", {31'd0, bus.if_ready & bus.d_ready}, 32'd0);
            chk("latency", 32'(cyc - t0 + 1), 32'(r.lat));
            if (r.is_data) begin
                chk("d_err", {31'd0, bus.d_err}, {31'd0, r.err});
                chk("d_rdata", bus.d_rdata, r.rdata);
            end else begin
                chk("if_rdata", bus.if_rdata, r.rdata);
            end
            if (mis) begin
                chk("mis_no_bus", 32'(req_cycles - start_req), 32'd0);
                chk("mis_we", {28'd0, bus.sram_we}, 32'd0);
            end
        end
        drop_reqs();
    endtask

    initial begin
        bit seen, exp_g;
        int nrdy, nreq;
        reset = 1'b1;
        drop_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sram_req", {31'd0, bus.sram_req}, 32'd0);
        chk("rst_ready", {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
        chk("rst_sram_we", {28'd0, bus.sram_we}, 32'd0);
        chk("rst_sram_addr", bus.sram_addr, 32'd0);
        chk("rst_rdata", bus.if_rdata | bus.d_rdata | bus.sram_wdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // fetch, addr low bits ignored, byte/half/word stores, loads, misaligned
        do_req(1, 32'h1C00_0000, 0, 2'd2, 0, 32'h0,          32'h1357_2468, 1);
        do_req(1, 32'h1C00_0006, 0, 2'd2, 0, 32'h0,          32'hCAFE_F00D, 0);
        do_req(0, 32'h0000_1003, 1, 2'd0, 0, 32'h0000_00AB, 32'h0, 0);
        do_req(0, 32'h0000_1002, 1, 2'd1, 0, 32'hFFFF_1234, 32'h0, 0);
        do_req(0, 32'h0000_1004, 1, 2'd2, 0, 32'hDEAD_BEEF, 32'h0, 2);
        do_req(0, 32'h0000_2001, 0, 2'd0, 0, 32'h0,          32'h0000_F000, 0);
        do_req(0, 32'h0000_2001, 0, 2'd0, 1, 32'h0,          32'h0000_F000, 0);
        do_req(0, 32'h0000_2002, 0, 2'd1, 0, 32'h0,          32'h8001_0000, 0);
        do_req(0, 32'h0000_2002, 0, 2'd1, 1, 32'h0,          32'h8001_0000, 1);
        do_req(0, 32'h0000_2008, 0, 2'd3, 0, 32'h0,          32'h89AB_CDEF, 0);
        do_req(0, 32'h0000_3001, 0, 2'd1, 0, 32'h0,          32'h0, 0);
        do_req(0, 32'h0000_2006, 1, 2'd2, 0, 32'h1111_2222, 32'h0, 0);

        // both requesters held: arbitration pattern
        bus_chk = 1'b0;
        ack_dly = 0;
        rd_word = 32'h1122_3344;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_FAIR_EN
            grant_q.push_back((i % 5) != 4);
`else
            grant_q.push_back(1'b1);
`endif
        end
        @(posedge clk); #1;
        bus.if_req = 1'b1;  bus.if_addr = 32'h0000_0100;
        bus.d_req  = 1'b1;  bus.d_size  = 2'd2; bus.d_addr = 32'h0000_0200;
        for (int g = 0; g < 10; g++) begin
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                if (bus.if_ready || bus.d_ready) seen = 1'b1;
            end
            exp_g = grant_q.pop_front();
            if (!seen) chk("fair_timeout", 32'd0, 32'd1);
            else begin
                chk("fair_grant", {31'd0, bus.d_ready}, {31'd0, exp_g});
                chk("fair_rdata", bus.d_ready ? bus.d_rdata : bus.if_rdata, rd_word);
            end
        end
        drop_reqs();
        bus_chk = 1'b1;

        // reset while DATA waits for ack, then a stray ack in IDLE
        ack_dly = 100;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_size = 2'd2; bus.d_addr = 32'h0000_0400;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_in_data", {31'd0, bus.sram_req}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        drop_reqs();
        @(posedge clk); #1;
        reset = 1'b0;
        force_ack = 1'b1;
        nrdy = 0;
        nreq = 0;
        @(negedge clk);
        if (bus.if_ready || bus.d_ready) nrdy++;
        if (bus.sram_req) nreq++;
        @(posedge clk); #1;
        force_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.if_ready || bus.d_ready) nrdy++;
            if (bus.sram_req) nreq++;
        end
        chk("abort_no_ready", 32'(nrdy), 32'd0);
        chk("abort_no_req", 32'(nreq), 32'd0);

        do_req(0, 32'h0000_0500, 0, 2'd0, 1, 32'h0, 32'h7788_99AA, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the maximum number of consecutive data grants while fetch is pending; legal range is 1..15.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  is a synchronous, active-high reset.
REQ-004 if_req  input  1  is the fetch request; it is held with if_addr stable until if_ready.
REQ-005 if_addr  input  32  is the fetch word address; bits [1:0] are ignored.
REQ-006 if_rdata  output  32  is the fetched word; valid only while if_ready=1.
REQ-007 if_ready  output  1  is a one-cycle completion pulse for fetch.
REQ-008 d_req / d_we  input  1 / 1  are the data request and write-select; both are held until d_ready.
REQ-009 d_size  input  2  is the access size: 0 = byte, 1 = half, 2 = word.
REQ-010 d_unsign  input  1  selects zero-extension (1) or sign-extension (0) of loads.
REQ-011 d_addr / d_wdata  input  32 / 32  are the byte address and the store data (right-aligned).
REQ-012 d_rdata  output  32  is the extended load data; valid only while d_ready=1.
REQ-013 d_ready / d_err  output  1 / 1  are the one-cycle completion pulse and the misalignment flag (meaningful only with d_ready).
REQ-014 sram_req  output  1  is the bus request; it is held until sram_ack.
REQ-015 sram_we  output  4  are the byte write enables; all 0 for reads.
REQ-016 sram_addr / sram_wdata  output  32 / 32  are the word-aligned address ([1:0]=0) and the lane-placed write data.
REQ-017 sram_rdata / sram_ack  input  32 / 1  are the read data and the completion; sram_rdata is valid in the sram_ack cycle.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, DATA and RESP; exactly one bus transaction is outstanding at a time.
REQ-019 In IDLE, with d_req=1 and the access aligned, the FSM SHALL enter DATA and assert sram_req on the next cycle.
- Exception: if if_req=1 and the starvation counter equals STARVE_MAX, the FSM SHALL enter FETCH instead.
REQ-020 In IDLE, with if_req=1 only, the FSM SHALL enter FETCH.
REQ-021 In FETCH or DATA, on sram_ack the FSM SHALL register rdata and enter RESP.
- The matching ready output SHALL pulse in RESP, and RESP SHALL then return to IDLE.
- Minimum latency is 3 cycles from request to ready with a zero-wait ack.
REQ-022 Alignment rule: half with d_addr[0]=1, or word with d_addr[1:0]!=0, is misaligned.
- A misaligned access SHALL go IDLE -> RESP with d_err=1 and no bus access.
- In that case d_rdata=0 and sram_we stays 0.
REQ-023 Store byte enables SHALL be: byte 4'b0001<<d_addr[1:0]; half 4'b0011<<{d_addr[1],1'b0}; word 4'b1111.
REQ-024 Store data SHALL be placed on the lanes: byte replicated x4, half replicated x2, word unchanged.
REQ-025 Load data SHALL select the addressed byte or half lane from the registered word, then sign- or zero-extend it per d_unsign.
REQ-026 Fetch SHALL read the full word; if_rdata is the registered sram_rdata.
REQ-027 A d_size value of 3 SHALL be treated as word.
REQ-028 All outputs not explicitly driven SHALL be 0; if_ready and d_ready are never asserted in the same cycle.

Reset
REQ-029 On reset the FSM SHALL go to IDLE, the starvation counter SHALL clear, and all outputs SHALL be 0.
REQ-030 Reset asserted while a transaction is outstanding SHALL abort it with no ready pulse.
- An sram_ack arriving in IDLE SHALL be ignored.

Configuration
REQ-031 With MEM_ARB_FAIR_EN defined, the 4-bit starvation counter SHALL operate as follows:
- increment on each data grant while if_req=1;
- clear on each fetch grant;
- saturate at STARVE_MAX.
REQ-032 Without MEM_ARB_FAIR_EN, data SHALL always win over fetch and no counter SHALL exist.

Structure
REQ-033 The ArbState enum and the MemSize constants (MEM_B, MEM_H, MEM_W) SHALL reside in shared package cpuDefine.
REQ-034 Load lane select and extension SHALL be implemented in combinational sub-module load_align, instantiated once.

Verification
REQ-035 Fetch with if_addr=0x1C000000 and ack one cycle after sram_req -> sram_addr=0x1C000000, if_ready in RESP, if_rdata matches sram_rdata.
REQ-036 Store byte with d_addr=0x1003 and d_wdata=0xAB -> sram_we=4'b1000, sram_wdata=0xABABABAB, sram_addr=0x1000.
REQ-037 Load byte with d_addr=0x2001, sram_rdata=0x0000F000 -> d_rdata=0xFFFFFFF0 with d_unsign=0, and 0x000000F0 with d_unsign=1.
REQ-038 Load half with d_addr=0x3001 -> d_ready=1 and d_err=1 two cycles after request, with no sram_req.
REQ-039 FAIR_EN on, STARVE_MAX=4, if_req and d_req both held continuously -> 4 data grants, then 1 fetch grant, then the pattern repeats.
REQ-040 Reset asserted in DATA before sram_ack -> IDLE, no d_ready, and a following ack is ignored.
